// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle datapath. The fetch/PC stage and
// the opcode decoder both use it.
//   - opcode encodings (R-type .. jmp, plus the halt opcode)
//   - the bubble instruction driven while no instruction is live
//   - fetch FSM state encoding
//   - bit positions inside the decoder's branch vector
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_ANDI  = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b000101;
    localparam logic [5:0] OP_BEQ   = 6'b000110;
    localparam logic [5:0] OP_BNE   = 6'b000111;
    localparam logic [5:0] OP_SLTI  = 6'b001000;
    localparam logic [5:0] OP_JMP   = 6'b001001;
    localparam logic [5:0] HALT_OP  = 6'b111111;

    // Carries the halt opcode with all other fields zero; the decoder
    // turns it into an instruction with no register or memory writes.
    localparam logic [31:0] BUBBLE_INSTR = 32'hFC00_0000;

    localparam int BR_EQ = 0;
    localparam int BR_NE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   i_pc       current program counter
//   i_instr    instruction presented this cycle (bubble when not live)
//   i_jump     decoder jump request
//   i_branch   decoder branch request, [BR_EQ]=beq, [BR_NE]=bne
//   i_zero     ALU zero flag for the current instruction
//   o_pc_plus4 sequential successor address
//   o_next_pc  selected successor: jump, then taken branch, then pc+4
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_jump,
    input  logic [1:0]  i_branch,
    input  logic        i_zero,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_seimm;
    logic [31:0] w_btarget;
    logic [31:0] w_jtarget;
    logic        w_taken;

    assign o_pc_plus4 = i_pc + 32'd4;
    assign w_seimm    = {{16{i_instr[15]}}, i_instr[15:0]};
    assign w_btarget  = o_pc_plus4 + (w_seimm << 2);
    assign w_jtarget  = {o_pc_plus4[31:28], i_instr[25:0], 2'b00};
    // Both terms are ORed, so branch==2'b11 is taken whatever zero is.
    assign w_taken    = (i_branch[BR_EQ] & i_zero) | (i_branch[BR_NE] & ~i_zero);

    // Successor priority: jump over taken branch over fall-through.
    always_comb begin
        o_next_pc = o_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_jtarget;
        end else if (w_taken) begin
            o_next_pc = w_btarget;
        end else begin
            o_next_pc = o_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / program-counter stage feeding the opcode decoder.
// Holds the PC, addresses instruction memory, presents the live instruction
// and sequences IDLE -> RUN -> HALT with stall, range fault and a
// retired-instruction counter.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pulse: leave IDLE, or restart from HALT
//   stall           hold PC and counter this cycle
//   jump, branch    decoder control-flow requests
//   zero            ALU zero flag for the current instruction
//   imem_data       combinational read of imem_addr
//   imem_addr, pc   current PC (byte address)
//   pc_plus4        pc + 4
//   instr, op       live instruction (bubble when !valid) and its opcode
//   valid           instruction live this cycle
//   halted          FSM in HALT
//   fault           sticky: PC left instruction memory
//   retired         instructions retired since start
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_DEPTH   = 256,
    parameter logic [5:0]  HALT_OP      = cpu_pkg::HALT_OP,
    parameter logic [31:0] BUBBLE_INSTR = cpu_pkg::BUBBLE_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        jump,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    import cpu_pkg::*;

    // One past the last byte address; 33 bits so the limit itself never wraps.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_retired;
    logic        r_fault;

    logic        w_in_range;
    logic [31:0] w_next_pc;

    assign w_in_range = ({1'b0, r_pc} < PC_LIMIT);

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign valid     = (r_state == RUN) && w_in_range;
    assign instr     = valid ? imem_data : BUBBLE_INSTR;
    assign op        = instr[31:26];
    assign halted    = (r_state == HALT);
    assign fault     = r_fault;
    assign retired   = r_retired;

    next_pc_logic u_next_pc (
        .i_pc       (r_pc),
        .i_instr    (instr),
        .i_jump     (jump),
        .i_branch   (branch),
        .i_zero     (zero),
        .o_pc_plus4 (pc_plus4),
        .o_next_pc  (w_next_pc)
    );

    // Fetch FSM with PC, retired counter and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_retired <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (stall) begin
                        r_pc <= r_pc;
                    end else if (!w_in_range) begin
                        // Range is checked before the opcode: an out-of-range
                        // PC presents the bubble, which carries HALT_OP.
                        r_fault <= 1'b1;
                        r_state <= HALT;
                    end else if (op == HALT_OP) begin
                        r_state <= HALT;
                    end else begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + 32'd1;
                    end
                end
                HALT: begin
                    if (start) begin
                        r_pc      <= RESET_PC;
                        r_retired <= 32'd0;
                        r_fault   <= 1'b0;
                        r_state   <= RUN;
                    end else begin
                        r_state <= HALT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a full-size instance, a 4-word instance
// for the range fault, and a standalone next_pc_logic for wide-address cases.
module tb_fetch_pc_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [1:0]  branch = 2'b00;
    logic        zero = 1'b0;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:3];

    logic [31:0] imem_data_a, imem_addr_a, instr_a, pc_a, pc_plus4_a, retired_a;
    logic [5:0]  op_a;
    logic        valid_a, halted_a, fault_a;
    logic [31:0] imem_data_b, imem_addr_b, instr_b, pc_b, pc_plus4_b, retired_b;
    logic [5:0]  op_b;
    logic        valid_b, halted_b, fault_b;

    logic [31:0] u_pc, u_instr, u_pc_plus4, u_next_pc;
    logic        u_jump, u_zero;
    logic [1:0]  u_branch;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] ADDI_W = {OP_ADDI, 5'd1, 5'd1, 16'd1};
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    assign imem_data_a = mem_a[imem_addr_a[9:2]];
    assign imem_data_b = mem_b[imem_addr_b[3:2]];

    always #5 clk = ~clk;

    fetch_pc_unit dut_a (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .jump(jump),
        .branch(branch), .zero(zero), .imem_data(imem_data_a),
        .imem_addr(imem_addr_a), .instr(instr_a), .op(op_a), .pc(pc_a),
        .pc_plus4(pc_plus4_a), .valid(valid_a), .halted(halted_a),
        .fault(fault_a), .retired(retired_a)
    );

    fetch_pc_unit #(.IMEM_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .jump(jump),
        .branch(branch), .zero(zero), .imem_data(imem_data_b),
        .imem_addr(imem_addr_b), .instr(instr_b), .op(op_b), .pc(pc_b),
        .pc_plus4(pc_plus4_b), .valid(valid_b), .halted(halted_b),
        .fault(fault_b), .retired(retired_b)
    );

    next_pc_logic u_npc (
        .i_pc(u_pc), .i_instr(u_instr), .i_jump(u_jump), .i_branch(u_branch),
        .i_zero(u_zero), .o_pc_plus4(u_pc_plus4), .o_next_pc(u_next_pc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rst for one edge, then a start pulse: PC at RESET_PC in RUN.
    task automatic reset_and_start();
        rst = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; branch = 2'b00; zero = 1'b0;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // From pc=0 take a jump to 0x10 with a beq asserted alongside.
    task automatic go_to_0x10();
        reset_and_start();
        jump = 1'b1; branch = 2'b01; zero = 1'b1;
        tick();
        jump = 1'b0; branch = 2'b00; zero = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = ADDI_W;
        for (int i = 0; i < 4; i++) mem_b[i] = ADDI_W;
        u_pc = 32'd0; u_instr = 32'd0; u_jump = 1'b0; u_branch = 2'b00; u_zero = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_halted", {31'd0, halted_a}, 32'd0);
        chk("rst_fault", {31'd0, fault_a}, 32'd0);
        chk("rst_retired", retired_a, 32'd0);
        chk("rst_instr", instr_a, HALT_W);
        rst = 1'b0;
        tick();
        chk("idle_hold_pc", pc_a, 32'h0);
        chk("idle_hold_valid", {31'd0, valid_a}, 32'd0);

        // Sequential run to HALT at 12
        mem_a[3] = HALT_W;
        start = 1'b1; tick(); start = 1'b0;
        chk("seq_pc0", pc_a, 32'h0);
        chk("seq_valid", {31'd0, valid_a}, 32'd1);
        chk("seq_instr", instr_a, ADDI_W);
        chk("seq_op", {26'd0, op_a}, {26'd0, OP_ADDI});
        chk("seq_pc_plus4", pc_plus4_a, 32'h4);
        tick(); chk("seq_pc4", pc_a, 32'h4);
        tick(); chk("seq_pc8", pc_a, 32'h8);
        tick(); chk("seq_pc12", pc_a, 32'hC);
        chk("seq_op_halt", {26'd0, op_a}, {26'd0, HALT_OP});
        chk("seq_not_halted_yet", {31'd0, halted_a}, 32'd0);
        tick();
        chk("seq_halted", {31'd0, halted_a}, 32'd1);
        chk("seq_retired", retired_a, 32'd3);
        chk("seq_halt_pc", pc_a, 32'hC);
        chk("seq_halt_instr", instr_a, HALT_W);
        chk("seq_halt_valid", {31'd0, valid_a}, 32'd0);
        tick();
        chk("seq_halt_hold_pc", pc_a, 32'hC);

        // Restart from HALT, then stall at pc=8
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_pc", pc_a, 32'h0);
        chk("restart_retired", retired_a, 32'd0);
        chk("restart_halted", {31'd0, halted_a}, 32'd0);
        tick(); tick();
        chk("stall_pre_pc", pc_a, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_a, 32'h8);
            chk("stall_valid", {31'd0, valid_a}, 32'd1);
            chk("stall_retired", retired_a, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("stall_release_pc", pc_a, 32'hC);
        chk("stall_release_retired", retired_a, 32'd3);

        // Branches at 0x10 (jump at pc 0 also checks jump beats beq)
        mem_a[3] = ADDI_W;
        mem_a[0] = {OP_JMP, 26'h4};
        mem_a[4] = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
        go_to_0x10();
        chk("jump_over_beq_pc", pc_a, 32'h10);
        branch = 2'b01; zero = 1'b1; tick();
        chk("beq_taken_pc", pc_a, 32'hC);
        chk("beq_taken_retired", retired_a, 32'd2);
        go_to_0x10();
        branch = 2'b01; zero = 1'b0; tick();
        chk("beq_not_taken_pc", pc_a, 32'h14);
        mem_a[4] = {OP_BNE, 5'd1, 5'd2, 16'd3};
        go_to_0x10();
        branch = 2'b10; zero = 1'b0; tick();
        chk("bne_taken_pc", pc_a, 32'h20);
        go_to_0x10();
        branch = 2'b10; zero = 1'b1; tick();
        chk("bne_not_taken_pc", pc_a, 32'h14);
        go_to_0x10();
        branch = 2'b11; zero = 1'b0; tick();
        chk("br11_taken_pc", pc_a, 32'h20);
        branch = 2'b00;

        // Wide-address next-PC cases on the standalone selector
        u_pc = 32'h8000_0004; u_instr = {OP_JMP, 26'h10};
        u_jump = 1'b1; u_branch = 2'b01; u_zero = 1'b1;
        #1;
        chk("npc_jump_wins", u_next_pc, 32'h8000_0040);
        u_jump = 1'b0; u_branch = 2'b00; u_pc = 32'hFFFF_FFFC;
        #1;
        chk("npc_wrap", u_next_pc, 32'h0);

        // Range fault on the 4-word instance
        mem_b[0] = {OP_JMP, 26'h10};
        reset_and_start();
        jump = 1'b1; tick(); jump = 1'b0;
        chk("fault_jump_pc", pc_b, 32'h40);
        chk("fault_oob_valid", {31'd0, valid_b}, 32'd0);
        chk("fault_not_yet", {31'd0, fault_b}, 32'd0);
        tick();
        chk("fault_set", {31'd0, fault_b}, 32'd1);
        chk("fault_halted", {31'd0, halted_b}, 32'd1);
        chk("fault_valid", {31'd0, valid_b}, 32'd0);
        chk("fault_pc_hold", pc_b, 32'h40);
        chk("fault_retired", retired_b, 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("fault_restart_pc", pc_b, 32'h0);
        chk("fault_cleared", {31'd0, fault_b}, 32'd0);
        chk("fault_restart_retired", retired_b, 32'd0);
        chk("fault_restart_run", {31'd0, valid_b}, 32'd1);

        // Reset mid-run at pc=0x24, retired=9; start ignored in RUN
        mem_a[0] = ADDI_W;
        mem_a[4] = ADDI_W;
        reset_and_start();
        for (int i = 0; i < 9; i++) begin
            start = (i == 3 || i == 4) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        chk("midrun_pc", pc_a, 32'h24);
        chk("midrun_retired", retired_a, 32'd9);
        rst = 1'b1; tick();
        chk("midrst_pc", pc_a, 32'h0);
        chk("midrst_retired", retired_a, 32'd0);
        chk("midrst_valid", {31'd0, valid_a}, 32'd0);
        chk("midrst_halted", {31'd0, halted_a}, 32'd0);
        rst = 1'b0; tick();
        chk("midrst_idle_pc", pc_a, 32'h0);
        chk("midrst_idle_valid", {31'd0, valid_a}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
